// File: rtl/fp_mc_sequencer.sv
// fp_mc_sequencer: issue/writeback controller for the FPU multi-cycle units
// (square root and divide). It accepts one request over valid/ready, pulses the
// selected unit's start and holds its operands and rounding mode stable. On the
// unit's done it captures the result and flags, then presents them to writeback
// with the request tag.
// A flush drops the request architecturally. The unit itself is allowed to drain.
//
// Optional build macro FP_MC_TIMEOUT_EN adds a watchdog on WAIT/DRAIN. A stuck
// unit then produces a canonical-NaN writeback, and timeout_err is set sticky.
module fp_mc_sequencer #(
    parameter int FLEN           = 32,
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [2:0]       req_rm,
    input  logic [FLEN-1:0]  req_rs1,
    input  logic [FLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             sqrt_start,
    output logic [FLEN-1:0]  sqrt_operand,
    input  logic             sqrt_done,
    input  logic [FLEN-1:0]  sqrt_result,
    input  logic             sqrt_flag_nv,
    input  logic             sqrt_flag_nx,
    output logic             div_start,
    output logic [FLEN-1:0]  div_operand_a,
    output logic [FLEN-1:0]  div_operand_b,
    input  logic             div_done,
    input  logic [FLEN-1:0]  div_result,
    input  logic             div_flag_nv,
    input  logic             div_flag_dz,
    input  logic             div_flag_of,
    input  logic             div_flag_uf,
    input  logic             div_flag_nx,
    output logic [2:0]       rm_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [FLEN-1:0]  wb_result,
    output logic [TAG_W-1:0] wb_tag,
    output logic [4:0]       wb_fflags,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [FLEN-1:0] CANON_NAN = (FLEN == 64) ? FLEN'(64'h7FF8_0000_0000_0000)
                                                         : FLEN'(32'h7FC0_0000);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             op_r;
    logic [2:0]       rm_r;
    logic [FLEN-1:0]  opa_r;
    logic [FLEN-1:0]  opb_r;
    logic [TAG_W-1:0] tag_r;
    logic [FLEN-1:0]  result_r;
    logic [4:0]       fflags_r;

    logic             accept_s;
    logic             done_sel_s;
    logic             tmo_hit_s;
    logic             cap_done_s;
    logic             cap_tmo_s;
    logic [FLEN-1:0]  unit_result_s;
    logic [4:0]       unit_fflags_s;

    // Acceptance is only possible in IDLE, and a same-cycle flush blocks it.
    assign req_ready = (state_r == ST_IDLE) && !flush;
    assign accept_s  = req_valid && req_ready;

    // Only the unit that was launched can complete this request.
    assign done_sel_s    = op_r ? div_done : sqrt_done;
    assign unit_result_s = op_r ? div_result : sqrt_result;
    assign unit_fflags_s = op_r ? {div_flag_nv, div_flag_dz, div_flag_of, div_flag_uf, div_flag_nx}
                                : {sqrt_flag_nv, 3'b000, sqrt_flag_nx};

    // Start pulses and status are decoded from the state register; ISSUE lasts one cycle.
    assign sqrt_start    = (state_r == ST_ISSUE) && !op_r;
    assign div_start     = (state_r == ST_ISSUE) && op_r;
    assign wb_valid      = (state_r == ST_HOLD);
    assign busy          = (state_r != ST_IDLE);

    // Operands and rm come straight from the request latches.
    // They stay constant from ISSUE until the next accept.
    assign sqrt_operand  = opa_r;
    assign div_operand_a = opa_r;
    assign div_operand_b = opb_r;
    assign rm_out        = rm_r;
    assign wb_result     = result_r;
    assign wb_tag        = tag_r;
    assign wb_fflags     = fflags_r;

`ifdef FP_MC_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             timeout_err_r;
    logic             in_wd_s;
    logic             enter_wd_s;
    logic             err_set_s;

    assign in_wd_s    = (state_r == ST_WAIT) || (state_r == ST_DRAIN);
    assign enter_wd_s = (state_s != state_r) && ((state_s == ST_WAIT) || (state_s == ST_DRAIN));
    assign tmo_hit_s  = in_wd_s && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    // Flag the error only when the watchdog, not a done or flush, ended the wait.
    assign err_set_s  = cap_tmo_s || ((state_r == ST_DRAIN) && tmo_hit_s && !done_sel_s);
    assign timeout_err = timeout_err_r;

    // Watchdog counter: restarts on every entry to WAIT/DRAIN, counts while there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (enter_wd_s) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (in_wd_s && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky timeout error, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err_r <= 1'b0;
        end else if (err_set_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end
`else
    assign tmo_hit_s   = 1'b0;
    assign timeout_err = 1'b0;

    // TIMEOUT_CYCLES only sizes the watchdog; without it the parameter is accepted but inert.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and capture strobes.
    // Priority is flush, then done, then watchdog.
    always_comb begin
        state_s    = state_r;
        cap_done_s = 1'b0;
        cap_tmo_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The start pulse goes out this cycle regardless; a flush just skips writeback.
                if (flush) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    if (done_sel_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end else if (done_sel_s) begin
                    state_s    = ST_HOLD;
                    cap_done_s = 1'b1;
                end else if (tmo_hit_s) begin
                    state_s   = ST_HOLD;
                    cap_tmo_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (done_sel_s || tmo_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (flush || wb_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request latches (op, rm, operands, tag), loaded only on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r  <= 1'b0;
            rm_r  <= 3'b000;
            opa_r <= {FLEN{1'b0}};
            opb_r <= {FLEN{1'b0}};
            tag_r <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            op_r  <= req_op;
            rm_r  <= req_rm;
            opa_r <= req_rs1;
            opb_r <= req_rs2;
            tag_r <= req_tag;
        end else begin
            op_r  <= op_r;
            rm_r  <= rm_r;
            opa_r <= opa_r;
            opb_r <= opb_r;
            tag_r <= tag_r;
        end
    end

    // Writeback result and flags, loaded from the unit or from the watchdog.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_r <= {FLEN{1'b0}};
            fflags_r <= 5'b00000;
        end else if (cap_done_s) begin
            result_r <= unit_result_s;
            fflags_r <= unit_fflags_s;
        end else if (cap_tmo_s) begin
            result_r <= CANON_NAN;
            fflags_r <= 5'b10000;
        end else begin
            result_r <= result_r;
            fflags_r <= fflags_r;
        end
    end

endmodule

// File: tb/tb_fp_mc_sequencer.sv
// Directed testbench for fp_mc_sequencer. The bench plays the role of both
// multi-cycle units. Expected writebacks are queued when a request is issued
// and checked when wb_valid appears.
module tb_fp_mc_sequencer;

    localparam int FLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [2:0]       req_rm = 3'b000;
    logic [FLEN-1:0]  req_rs1 = 32'h0;
    logic [FLEN-1:0]  req_rs2 = 32'h0;
    logic [TAG_W-1:0] req_tag = 5'd0;
    logic             flush = 1'b0;
    logic             sqrt_start;
    logic [FLEN-1:0]  sqrt_operand;
    logic             sqrt_done = 1'b0;
    logic [FLEN-1:0]  sqrt_result = 32'h0;
    logic             sqrt_flag_nv = 1'b0;
    logic             sqrt_flag_nx = 1'b0;
    logic             div_start;
    logic [FLEN-1:0]  div_operand_a;
    logic [FLEN-1:0]  div_operand_b;
    logic             div_done = 1'b0;
    logic [FLEN-1:0]  div_result = 32'h0;
    logic             div_flag_nv = 1'b0;
    logic             div_flag_dz = 1'b0;
    logic             div_flag_of = 1'b0;
    logic             div_flag_uf = 1'b0;
    logic             div_flag_nx = 1'b0;
    logic [2:0]       rm_out;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [FLEN-1:0]  wb_result;
    logic [TAG_W-1:0] wb_tag;
    logic [4:0]       wb_fflags;
    logic             busy;
    logic             timeout_err;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [4:0]  ff;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      checks = 0;
    int      errors = 0;

    fp_mc_sequencer #(
        .FLEN(FLEN), .TAG_W(TAG_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
        .sqrt_start(sqrt_start), .sqrt_operand(sqrt_operand), .sqrt_done(sqrt_done),
        .sqrt_result(sqrt_result), .sqrt_flag_nv(sqrt_flag_nv), .sqrt_flag_nx(sqrt_flag_nx),
        .div_start(div_start), .div_operand_a(div_operand_a), .div_operand_b(div_operand_b),
        .div_done(div_done), .div_result(div_result), .div_flag_nv(div_flag_nv),
        .div_flag_dz(div_flag_dz), .div_flag_of(div_flag_of), .div_flag_uf(div_flag_uf),
        .div_flag_nx(div_flag_nx), .rm_out(rm_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_tag(wb_tag),
        .wb_fflags(wb_fflags), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns one cycle later with the DUT in ISSUE.
    task automatic drive_req(input logic op, input logic [2:0] rm, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_rm    = rm;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        #1;
        chk("accept_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        req_rs1   = 32'hDEAD_BEEF;
        req_rs2   = 32'hDEAD_BEEF;
    endtask

    task automatic check_start(input logic op);
        chk("sqrt_start", sqrt_start, !op);
        chk("div_start", div_start, op);
        chk("busy_issue", busy, 1'b1);
        chk("ready_issue", req_ready, 1'b0);
    endtask

    // One-cycle done pulse from the selected unit model; flags are {nv,dz,of,uf,nx}.
    task automatic pulse_done(input logic op, input logic [31:0] res, input logic [4:0] fl);
        if (op) begin
            div_done    = 1'b1;
            div_result  = res;
            {div_flag_nv, div_flag_dz, div_flag_of, div_flag_uf, div_flag_nx} = fl;
        end else begin
            sqrt_done    = 1'b1;
            sqrt_result  = res;
            sqrt_flag_nv = fl[4];
            sqrt_flag_nx = fl[0];
        end
        tick();
        div_done     = 1'b0;
        sqrt_done    = 1'b0;
        div_result   = 32'h0;
        sqrt_result  = 32'h0;
        {div_flag_nv, div_flag_dz, div_flag_of, div_flag_uf, div_flag_nx} = 5'b00000;
        sqrt_flag_nv = 1'b0;
        sqrt_flag_nx = 1'b0;
    endtask

    // Compare the presented writeback to the scoreboard head and complete the handshake.
    task automatic expect_wb();
        wb_exp_t e;
        chk("wb_valid", wb_valid, 1'b1);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk("wb_result", wb_result, e.res);
            chk("wb_tag", wb_tag, e.tag);
            chk("wb_fflags", wb_fflags, e.ff);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk("wb_drop", wb_valid, 1'b0);
        chk("idle_after_wb", busy, 1'b0);
        chk("ready_after_wb", req_ready, 1'b1);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sqrt_start", sqrt_start, 1'b0);
        chk("rst_div_start", div_start, 1'b0);
        chk("rst_wb_result", wb_result, 32'h0);
        chk("rst_wb_tag", wb_tag, 5'd0);
        chk("rst_wb_fflags", wb_fflags, 5'd0);
        chk("rst_operand", div_operand_b, 32'h0);
        chk("rst_timeout", timeout_err, 1'b0);
        reset_n = 1'b1;
        tick();

        // Sqrt(4.0) = 2.0, tag 7
        sb_q.push_back('{res: 32'h4000_0000, tag: 5'd7, ff: 5'b00000});
        drive_req(1'b0, 3'b000, 32'h4080_0000, 32'h0, 5'd7);
        check_start(1'b0);
        chk("sqrt_operand", sqrt_operand, 32'h4080_0000);
        tick();
        chk("sqrt_start_once", sqrt_start, 1'b0);
        chk("div_start_wait", div_start, 1'b0);
        pulse_done(1'b0, 32'h4000_0000, 5'b00000);
        expect_wb();

        // Div 1.0 / 0.0 -> +inf with DZ
        sb_q.push_back('{res: 32'h7F80_0000, tag: 5'd3, ff: 5'b01000});
        drive_req(1'b1, 3'b001, 32'h3F80_0000, 32'h0000_0000, 5'd3);
        check_start(1'b1);
        chk("div_opa", div_operand_a, 32'h3F80_0000);
        chk("rm_out", rm_out, 3'b001);
        tick();
        tick();
        chk("div_opa_hold", div_operand_a, 32'h3F80_0000);
        chk("div_opb_hold", div_operand_b, 32'h0);
        pulse_done(1'b1, 32'h7F80_0000, 5'b01000);
        expect_wb();

        // Sqrt with nv/nx; writeback stalled 5 cycles while a new request is offered
        sb_q.push_back('{res: 32'h7FC0_0000, tag: 5'd9, ff: 5'b10001});
        drive_req(1'b0, 3'b010, 32'hBF80_0000, 32'h1234_5678, 5'd9);
        tick();
        pulse_done(1'b0, 32'h7FC0_0000, 5'b11111);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_tag   = 5'd1;
        req_rs1   = 32'h1111_1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", wb_valid, 1'b1);
            chk("hold_result", wb_result, 32'h7FC0_0000);
            chk("hold_tag", wb_tag, 5'd9);
            chk("hold_ready", req_ready, 1'b0);
            chk("hold_no_start", div_start, 1'b0);
            tick();
        end
        req_valid = 1'b0;
        expect_wb();

        // Flush 3 cycles after ISSUE; done arrives later and is discarded
        drive_req(1'b1, 3'b011, 32'h4040_0000, 32'h4000_0000, 5'd4);
        check_start(1'b1);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_no_wb", wb_valid, 1'b0);
            chk("drain_busy", busy, 1'b1);
            chk("drain_opa", div_operand_a, 32'h4040_0000);
            chk("drain_opb", div_operand_b, 32'h4000_0000);
            tick();
        end
        pulse_done(1'b1, 32'h3FC0_0000, 5'b00001);
        chk("drain_idle", busy, 1'b0);
        chk("drain_ready", req_ready, 1'b1);
        chk("drain_wb", wb_valid, 1'b0);

        // Spurious div_done during a sqrt WAIT is ignored
        sb_q.push_back('{res: 32'h3FB5_04F3, tag: 5'd11, ff: 5'b00001});
        drive_req(1'b0, 3'b000, 32'h4000_0000, 32'h0, 5'd11);
        tick();
        pulse_done(1'b1, 32'hFFFF_FFFF, 5'b11111);
        chk("spurious_no_wb", wb_valid, 1'b0);
        chk("spurious_busy", busy, 1'b1);
        tick();
        pulse_done(1'b0, 32'h3FB5_04F3, 5'b00001);
        expect_wb();

        // Flush during ISSUE: start still issued, then drain
        drive_req(1'b0, 3'b000, 32'h4100_0000, 32'h0, 5'd2);
        flush = 1'b1;
        #1;
        chk("flush_issue_start", sqrt_start, 1'b1);
        tick();
        flush = 1'b0;
        chk("flush_issue_drain", busy, 1'b1);
        chk("flush_issue_once", sqrt_start, 1'b0);
        pulse_done(1'b0, 32'h4035_04F3, 5'b00001);
        chk("flush_issue_idle", busy, 1'b0);
        chk("flush_issue_wb", wb_valid, 1'b0);

        // Flush coinciding with done in WAIT goes straight to IDLE
        drive_req(1'b1, 3'b000, 32'h4000_0000, 32'h3F80_0000, 5'd5);
        tick();
        flush = 1'b1;
        pulse_done(1'b1, 32'h4000_0000, 5'b00000);
        flush = 1'b0;
        chk("flush_done_idle", busy, 1'b0);
        chk("flush_done_wb", wb_valid, 1'b0);

        // Flush in IDLE blocks acceptance
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_idle_ready", req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_idle_busy", busy, 1'b0);

        // Flush in HOLD drops the writeback
        drive_req(1'b0, 3'b000, 32'h4080_0000, 32'h0, 5'd6);
        tick();
        pulse_done(1'b0, 32'h4000_0000, 5'b00000);
        chk("hold_flush_pre", wb_valid, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hold_flush_wb", wb_valid, 1'b0);
        chk("hold_flush_idle", busy, 1'b0);

`ifdef FP_MC_TIMEOUT_EN
        // Divider never answers: watchdog forces a NaN writeback after 16 WAIT cycles
        begin
            int cyc;
            cyc = 0;
            sb_q.push_back('{res: 32'h7FC0_0000, tag: 5'd13, ff: 5'b10000});
            drive_req(1'b1, 3'b000, 32'h3F80_0000, 32'h4040_0000, 5'd13);
            while (!wb_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            chk("tmo_cycles", cyc, 17);
            chk("tmo_err", timeout_err, 1'b1);
            expect_wb();
            chk("tmo_err_sticky", timeout_err, 1'b1);
        end
`else
        chk("no_tmo_err", timeout_err, 1'b0);
`endif

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mc_sequencer.md
Name: fp_mc_sequencer

Overview:
Issue/writeback controller for the FPU's multi-cycle units: the initiator side of the start/busy/done protocol used by the square-root and divide units. It accepts one FSQRT or FDIV request from the FP pipeline over a valid/ready handshake, launches the selected unit and holds its operands stable. It then captures the unit's result and flags on done and presents them to writeback with a tag. Flushes abort the request architecturally while the hardware unit is allowed to drain.

Parameters:
FLEN, 32, operand/result width (32 or 64)
TAG_W, 5, request tag width (destination register)
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with FP_MC_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  sequencer can accept a request
req_op  in  1  0 = sqrt, 1 = div
req_rm  in  3  rounding mode
req_rs1  in  FLEN  operand A (sqrt operand / dividend)
req_rs2  in  FLEN  operand B (divisor; ignored for sqrt)
req_tag  in  TAG_W  tag returned with result
flush  in  1  pipeline flush
sqrt_start  out  1  one-cycle start pulse to sqrt unit
sqrt_operand  out  FLEN  sqrt operand
sqrt_done  in  1  sqrt completion pulse
sqrt_result  in  FLEN  sqrt result
sqrt_flag_nv, sqrt_flag_nx  in  1 each  sqrt flags
div_start  out  1  one-cycle start pulse to divider
div_operand_a, div_operand_b  out  FLEN each  divider operands
div_done  in  1  divider completion pulse
div_result  in  FLEN  divider result
div_flag_nv, div_flag_dz, div_flag_of, div_flag_uf, div_flag_nx  in  1 each  divider flags
rm_out  out  3  rounding mode to both units
wb_valid  out  1  result valid
wb_ready  in  1  writeback accepts
wb_result  out  FLEN  result
wb_tag  out  TAG_W  captured tag
wb_fflags  out  5  {NV,DZ,OF,UF,NX}
busy  out  1  any non-IDLE state
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE; all registers, including operands, tag, result, fflags and timeout_err, cleared. req_ready=1, wb_valid=0, starts=0.
- States: IDLE, ISSUE, WAIT, DRAIN, HOLD.
- IDLE: req_ready=1 only when flush=0. When req_valid&&req_ready, latch op, rm, rs1, rs2 and tag, then go to ISSUE. req_ready=0 in all other states.
- ISSUE: assert sqrt_start or div_start (per op) for exactly one cycle; the other start stays 0. Next state is WAIT.
- Operand outputs and rm_out are registered and held stable from ISSUE until the unit's done. The sqrt unit samples its operand after start and re-reads it for special values, so this hold is required.
- WAIT: monitor only the selected unit's done; the other unit's done is ignored.
  - On done: capture result and flags, go to HOLD.
  - For sqrt, fflags = {nv,0,0,0,nx}.
- HOLD: wb_valid=1, with wb_result, wb_tag and wb_fflags stable until wb_valid&&wb_ready. On that handshake go to IDLE; a new request can be accepted the following cycle.
- Latency: accept at cycle 0, start at cycle 1, wb_valid the cycle after done.
- Flush:
  - In ISSUE or WAIT: go to DRAIN. Units cannot be aborted, so the start in ISSUE is still issued.
  - In DRAIN: wait for the selected done, discard the result, go to IDLE; wb_valid is never raised.
  - If done and flush coincide in WAIT, flush wins and the state goes to IDLE directly.
  - In HOLD: drop wb_valid, go to IDLE.
  - In IDLE: blocks acceptance that cycle.
- busy = (state != IDLE).

Optional Feature:
FP_MC_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on entry to WAIT/DRAIN and increments each cycle there.
  - Reaching TIMEOUT_CYCLES in WAIT forces HOLD with result canonical NaN (0x7FC00000 for FLEN 32, 0x7FF8000000000000 for 64) and fflags 10000.
  - Reaching it in DRAIN forces IDLE.
  - Either case sets timeout_err sticky until reset.
- Undefined: no counter; timeout_err is tied 0.

Test Plan:
- Sqrt 0x40800000, tag 7, rm 000; unit returns 0x40000000 with flags 0 -> one sqrt_start pulse at cycle 1, div_start 0; wb_valid with result 0x40000000, tag 7, fflags 00000.
- Div 1.0/0.0; divider returns 0x7F800000 with dz=1 -> wb_fflags 01000, result 0x7F800000.
- wb_ready held 0 for 5 cycles in HOLD -> wb_valid, result and tag held stable; req_ready 0; a concurrent req_valid is not accepted.
- Flush 3 cycles after ISSUE; done arrives later -> no wb_valid; operands stable until done; IDLE and req_ready=1 the cycle after done.
- Spurious div_done during a sqrt WAIT -> ignored; completion only on sqrt_done.
- With FP_MC_TIMEOUT_EN and TIMEOUT_CYCLES=16, done never arrives -> HOLD after 16 cycles, result 0x7FC00000, fflags 10000, timeout_err=1 and remaining set after the writeback handshake.
